// File: rtl/frame_write_sequencer.sv
// Frame write sequencer: takes a header word naming a column/frame, then one
// data word, and plays out a SETUP / STROBE / HOLD write cycle towards the
// tile configuration memories.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a header word; decodes write / clear-error / bad op
// DATA   | header accepted, waiting (indefinitely) for the frame data word
// SETUP  | FrameData presented, no strobe yet
// STROBE | one-hot FrameStrobe and ColSelect driven for StrobeCycles cycles
// HOLD   | strobes released, FrameData held; frame counted on exit
`timescale 1ns/1ps

module frame_write_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumColumns      = 8,
    parameter int StrobeCycles    = 2
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [31:0]                s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [NumColumns-1:0]      ColSelect,
    output logic                       busy,
    output logic                       error,
    output logic [15:0]                frame_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [7:0] OP_WRITE     = 8'hC0;
    localparam logic [7:0] OP_CLR_ERROR = 8'hC1;

    // Limits widened by one bit so a count of 256 still compares correctly.
    localparam logic [8:0] NUM_COL_LIM   = 9'(NumColumns);
    localparam logic [8:0] NUM_FRAME_LIM = 9'(MaxFramesPerCol);

    // Strobe timer counts down to zero, so it is loaded with length-1.
    localparam logic [3:0] STROBE_LOAD = 4'(StrobeCycles - 1);

    logic [2:0]                 state_q, state_d;
    logic [7:0]                 column_q, column_d;
    logic [7:0]                 frame_q, frame_d;
    logic [3:0]                 strobe_cnt_q, strobe_cnt_d;
    logic [FrameBitsPerRow-1:0] frame_data_q, frame_data_d;
    logic                       error_q, error_d;
    logic [15:0]                frame_count_q, frame_count_d;

    logic       accept;
    logic [7:0] hdr_opcode;
    logic [7:0] hdr_column;
    logic [7:0] hdr_frame;
    logic       hdr_in_range;

    assign hdr_opcode   = s_data[31:24];
    assign hdr_column   = s_data[23:16];
    assign hdr_frame    = s_data[15:8];
    assign hdr_in_range = ({1'b0, hdr_column} < NUM_COL_LIM) &&
                          ({1'b0, hdr_frame}  < NUM_FRAME_LIM);

    // Ready is gated by reset so nothing is accepted while the block is held.
    assign s_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_DATA));
    assign accept  = s_valid && s_ready;

    // Next-state and datapath updates for the write sequence.
    always_comb begin
        state_d       = state_q;
        column_d      = column_q;
        frame_d       = frame_q;
        strobe_cnt_d  = strobe_cnt_q;
        frame_data_d  = frame_data_q;
        error_d       = error_q;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_opcode == OP_WRITE) begin
                        if (hdr_in_range) begin
                            column_d = hdr_column;
                            frame_d  = hdr_frame;
                            state_d  = ST_DATA;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (hdr_opcode == OP_CLR_ERROR) begin
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    frame_data_d = FrameBitsPerRow'(s_data);
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                strobe_cnt_d = STROBE_LOAD;
                state_d      = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    strobe_cnt_d = strobe_cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            column_q      <= 8'd0;
            frame_q       <= 8'd0;
            strobe_cnt_q  <= 4'd0;
            frame_data_q  <= '0;
            error_q       <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            column_q      <= column_d;
            frame_q       <= frame_d;
            strobe_cnt_q  <= strobe_cnt_d;
            frame_data_q  <= frame_data_d;
            error_q       <= error_d;
            frame_count_q <= frame_count_d;
        end
    end

    // One-hot strobe/column decode, live only in STROBE so at most one bit is set.
    always_comb begin
        FrameStrobe = '0;
        ColSelect   = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            FrameStrobe[i] = (state_q == ST_STROBE) && (int'(frame_q) == i);
        end
        for (int j = 0; j < NumColumns; j++) begin
            ColSelect[j] = (state_q == ST_STROBE) && (int'(column_q) == j);
        end
    end

    assign FrameData   = frame_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign error       = error_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed bench for frame_write_sequencer: one write cycle in detail, header
// error handling, DATA wait, back-to-back traffic, reset abort and counter wrap.
`timescale 1ns/1ps

module tb_frame_write_sequencer;

    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NC = 8;
    localparam int SC = 2;

    logic          CLK = 1'b0;
    logic          reset;
    logic [31:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [FB-1:0] FrameData;
    logic [MF-1:0] FrameStrobe;
    logic [NC-1:0] ColSelect;
    logic          busy;
    logic          error;
    logic [15:0]   frame_count;

    int checks = 0;
    int errors = 0;

    frame_write_sequencer #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NumColumns     (NC),
        .StrobeCycles   (SC)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .ColSelect  (ColSelect),
        .busy       (busy),
        .error      (error),
        .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        s_valid = v;
        s_data  = d;
        #1;
    endtask

    // Full write with no intermediate checks; returns with the DUT back in IDLE.
    task automatic write_frame(input logic [31:0] hdr, input logic [31:0] data);
        drive(1'b1, hdr);
        tick();
        drive(1'b1, data);
        tick();
        drive(1'b0, 32'h0);
        repeat (4) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0);
        repeat (3) tick();
        check("rst_ready_low", 32'(s_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(s_ready), 32'h1);
        check("post_rst_data", FrameData, 32'h0);
        check("post_rst_strobe", 32'(FrameStrobe), 32'h0);
        check("post_rst_col", 32'(ColSelect), 32'h0);
        check("post_rst_error", 32'(error), 32'h0);
        check("post_rst_count", 32'(frame_count), 32'h0);

        // Basic write: column 3, frame 5, data DEADBEEF.
        drive(1'b1, 32'hC003_0500);
        check("t1_idle_ready", 32'(s_ready), 32'h1);
        tick();
        drive(1'b1, 32'hDEAD_BEEF);
        check("t1_data_busy", 32'(busy), 32'h1);
        check("t1_data_ready", 32'(s_ready), 32'h1);
        tick();
        drive(1'b0, 32'h0);
        check("t1_setup_data", FrameData, 32'hDEAD_BEEF);
        check("t1_setup_strobe", 32'(FrameStrobe), 32'h0);
        check("t1_setup_col", 32'(ColSelect), 32'h0);
        check("t1_setup_ready", 32'(s_ready), 32'h0);
        tick();
        check("t1_strobe1_fs", 32'(FrameStrobe), 32'h0000_0020);
        check("t1_strobe1_cs", 32'(ColSelect), 32'h0000_0008);
        check("t1_strobe1_data", FrameData, 32'hDEAD_BEEF);
        tick();
        check("t1_strobe2_fs", 32'(FrameStrobe), 32'h0000_0020);
        check("t1_strobe2_cs", 32'(ColSelect), 32'h0000_0008);
        tick();
        check("t1_hold_fs", 32'(FrameStrobe), 32'h0);
        check("t1_hold_cs", 32'(ColSelect), 32'h0);
        check("t1_hold_data", FrameData, 32'hDEAD_BEEF);
        check("t1_hold_busy", 32'(busy), 32'h1);
        check("t1_hold_count", 32'(frame_count), 32'h0);
        tick();
        check("t1_idle_busy", 32'(busy), 32'h0);
        check("t1_idle_count", 32'(frame_count), 32'h1);
        check("t1_idle_data", FrameData, 32'hDEAD_BEEF);

        // Column out of range (8), then clear.
        drive(1'b1, 32'hC008_0000);
        tick();
        drive(1'b0, 32'h0);
        check("t2_col_error", 32'(error), 32'h1);
        check("t2_col_busy", 32'(busy), 32'h0);
        check("t2_col_ready", 32'(s_ready), 32'h1);
        check("t2_col_fs", 32'(FrameStrobe), 32'h0);
        tick();
        check("t2_col_fs2", 32'(FrameStrobe), 32'h0);
        check("t2_col_cs2", 32'(ColSelect), 32'h0);
        check("t2_col_count", 32'(frame_count), 32'h1);
        drive(1'b1, 32'hC100_0000);
        tick();
        drive(1'b0, 32'h0);
        check("t2_clr_error", 32'(error), 32'h0);

        // Frame out of range (20), then unknown opcode.
        drive(1'b1, 32'hC000_1400);
        tick();
        drive(1'b0, 32'h0);
        check("t3_frame_error", 32'(error), 32'h1);
        check("t3_frame_busy", 32'(busy), 32'h0);
        drive(1'b1, 32'hC100_0000);
        tick();
        drive(1'b0, 32'h0);
        check("t3_clr_error", 32'(error), 32'h0);
        drive(1'b1, 32'h7F00_0000);
        tick();
        drive(1'b0, 32'h0);
        check("t3_op_error", 32'(error), 32'h1);

        // Highest column/frame while error is set; DATA waits with s_valid low.
        drive(1'b1, 32'hC007_1300);
        tick();
        drive(1'b0, 32'h0);
        repeat (5) tick();
        check("t3_wait_busy", 32'(busy), 32'h1);
        check("t3_wait_ready", 32'(s_ready), 32'h1);
        check("t3_wait_data", FrameData, 32'hDEAD_BEEF);
        drive(1'b1, 32'h1234_5678);
        tick();
        drive(1'b0, 32'h0);
        check("t3_setup_data", FrameData, 32'h1234_5678);
        tick();
        check("t3_strobe_fs", 32'(FrameStrobe), 32'h0008_0000);
        check("t3_strobe_cs", 32'(ColSelect), 32'h0000_0080);
        check("t3_strobe_error", 32'(error), 32'h1);
        repeat (3) tick();
        check("t3_count", 32'(frame_count), 32'h2);
        check("t3_sticky_error", 32'(error), 32'h1);
        drive(1'b1, 32'hC100_0000);
        tick();
        drive(1'b0, 32'h0);
        check("t3_clr_error2", 32'(error), 32'h0);

        // Back-to-back words with s_valid held high.
        drive(1'b1, 32'hC001_0200);
        tick();
        drive(1'b1, 32'hA5A5_A5A5);
        tick();
        drive(1'b1, 32'hC002_0300);
        check("t4_setup_ready", 32'(s_ready), 32'h0);
        check("t4_setup_data", FrameData, 32'hA5A5_A5A5);
        tick();
        check("t4_strobe_ready", 32'(s_ready), 32'h0);
        check("t4_strobe_fs", 32'(FrameStrobe), 32'h0000_0004);
        check("t4_strobe_cs", 32'(ColSelect), 32'h0000_0002);
        tick();
        check("t4_strobe2_ready", 32'(s_ready), 32'h0);
        tick();
        check("t4_hold_ready", 32'(s_ready), 32'h0);
        tick();
        check("t4_idle_ready", 32'(s_ready), 32'h1);
        check("t4_idle_count", 32'(frame_count), 32'h3);
        tick();
        drive(1'b1, 32'h5A5A_5A5A);
        check("t4_data2_busy", 32'(busy), 32'h1);
        check("t4_data2_ready", 32'(s_ready), 32'h1);
        tick();
        drive(1'b0, 32'h0);
        check("t4_setup2_data", FrameData, 32'h5A5A_5A5A);
        tick();
        check("t4_strobe2_fs", 32'(FrameStrobe), 32'h0000_0008);
        check("t4_strobe2_cs", 32'(ColSelect), 32'h0000_0004);
        repeat (3) tick();
        check("t4_count2", 32'(frame_count), 32'h4);
        check("t4_error", 32'(error), 32'h0);

        // Reset during the second STROBE cycle aborts the frame.
        drive(1'b1, 32'hC004_0600);
        tick();
        drive(1'b1, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 32'h0);
        tick();
        tick();
        check("t5_strobe2_fs", 32'(FrameStrobe), 32'h0000_0040);
        check("t5_strobe2_cs", 32'(ColSelect), 32'h0000_0010);
        reset = 1'b1;
        #1;
        check("t5_rst_ready", 32'(s_ready), 32'h0);
        tick();
        check("t5_fs", 32'(FrameStrobe), 32'h0);
        check("t5_cs", 32'(ColSelect), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_data", FrameData, 32'h0);
        check("t5_count", 32'(frame_count), 32'h0);
        check("t5_error", 32'(error), 32'h0);
        reset = 1'b0;
        #1;
        check("t5_ready_after", 32'(s_ready), 32'h1);

        // Counter wrap from FFFF.
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        check("t6_preload", 32'(frame_count), 32'h0000_FFFF);
        write_frame(32'hC000_0000, 32'h1111_1111);
        check("t6_wrap", 32'(frame_count), 32'h0);
        check("t6_data", FrameData, 32'h1111_1111);
        check("t6_idle_fs", 32'(FrameStrobe), 32'h0);
        check("t6_idle_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
